// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core-side and memory-side bus bundle for dmem_arbiter
//
// Purpose: groups the per-core request/grant signals and the shared dmem port.
// Modports:
//   slave  - arbiter view: takes core requests and mem_read_data,
//            drives grant/stall/read data and the dmem port.
//   master - system view: the cores plus the memory model.
// Signals:
//   core_req/core_write/core_lock  per-core request, write enable, lock request
//   core_addr/core_write_data      packed per-core address and write data
//   core_read_data                 mem_read_data broadcast to all cores
//   core_grant/core_stall          per-core grant (one-hot or zero) and stall
//   mem_write/mem_addr/mem_write_data/mem_read_data  shared dmem port
interface dmem_arbiter_if #(
   parameter int NUM_CORES  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CORES-1:0]            core_req;
   logic [NUM_CORES-1:0]            core_write;
   logic [NUM_CORES-1:0]            core_lock;
   logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
   logic [NUM_CORES*DATA_WIDTH-1:0] core_write_data;
   logic [DATA_WIDTH-1:0]           core_read_data;
   logic [NUM_CORES-1:0]            core_grant;
   logic [NUM_CORES-1:0]            core_stall;
   logic                            mem_write;
   logic [ADDR_WIDTH-1:0]           mem_addr;
   logic [DATA_WIDTH-1:0]           mem_write_data;
   logic [DATA_WIDTH-1:0]           mem_read_data;

   modport slave (
      input  core_req, core_write, core_lock, core_addr, core_write_data,
      output core_read_data, core_grant, core_stall,
      output mem_write, mem_addr, mem_write_data,
      input  mem_read_data
   );

   modport master (
      output core_req, core_write, core_lock, core_addr, core_write_data,
      input  core_read_data, core_grant, core_stall,
      input  mem_write, mem_addr, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter with bounded lock and per-core counters
//
// Purpose: lets NUM_CORES cores share one single-port dmem. At most one core is
// granted per cycle; a granted core may hold the grant for up to LOCK_MAX
// consecutive cycles by asserting core_lock.
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous active-high reset; also gates grant/stall/mem outputs
//   bus          dmem_arbiter_if.slave: core requests in, grant/stall/read data out,
//                shared dmem port out (combinational read data back in)
//   stat_sel     selects which core's counters drive the stat outputs
//   stat_grants  saturating grant count of the selected core
//   stat_stalls  saturating stall-cycle count of the selected core
module dmem_arbiter #(
   parameter int NUM_CORES  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LOCK_MAX   = 4,
   localparam int PTR_W     = $clog2(NUM_CORES),
   localparam int CNT_W     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1
) (
   input  logic               clk,
   input  logic               reset,
   dmem_arbiter_if.slave      bus,
   input  logic [PTR_W-1:0]   stat_sel,
   output logic [31:0]        stat_grants,
   output logic [31:0]        stat_stalls
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   logic [PTR_W-1:0] rr_ptr, rr_nxt;
   logic             lock_active, lock_active_nxt;
   logic [PTR_W-1:0] lock_owner, lock_owner_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic [CNT_W-1:0] base_cnt;

   logic             scan_found;
   logic [PTR_W-1:0] scan_idx;
   logic             locked_grant;
   logic             grant_valid;
   logic [PTR_W-1:0] grant_idx;
   logic [NUM_CORES-1:0] grant_vec;

   logic [NUM_CORES-1:0][31:0] grant_cnt;
   logic [NUM_CORES-1:0][31:0] stall_cnt;

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] p);
      if (int'(p) == NUM_CORES - 1) return '0;
      return p + 1'b1;
   endfunction

   // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
   always_comb begin : scan_p
      int idx;
      scan_found = 1'b0;
      scan_idx   = '0;
      idx        = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CORES;
         if (!scan_found && bus.core_req[idx]) begin
            scan_found = 1'b1;
            scan_idx   = PTR_W'(idx);
         end
      end
   end

   // A live lock overrides round-robin only while its owner keeps requesting.
   assign locked_grant = lock_active & bus.core_req[lock_owner];
   assign grant_valid  = locked_grant | scan_found;
   assign grant_idx    = locked_grant ? lock_owner : scan_idx;

   always_comb begin
      grant_vec = '0;
      if (!reset && grant_valid) grant_vec[grant_idx] = 1'b1;
   end

   assign bus.core_grant     = grant_vec;
   assign bus.core_stall     = reset ? '0 : (bus.core_req & ~grant_vec);
   assign bus.core_read_data = bus.mem_read_data;

   always_comb begin
      bus.mem_write      = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      if (!reset && grant_valid) begin
         bus.mem_write      = bus.core_write[grant_idx];
         bus.mem_addr       = bus.core_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
         bus.mem_write_data = bus.core_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // lock_cnt counts granted cycles under the lock, including the cycle that
   // started it, so the owner gets at most LOCK_MAX back-to-back accesses.
   always_comb begin
      rr_nxt          = rr_ptr;
      lock_active_nxt = lock_active;
      lock_owner_nxt  = lock_owner;
      lock_cnt_nxt    = lock_cnt;
      base_cnt        = '0;
      // Owner dropped its request: release and hand the pointer past it.
      if (lock_active && !locked_grant) begin
         lock_active_nxt = 1'b0;
         lock_cnt_nxt    = '0;
         rr_nxt          = next_idx(lock_owner);
      end
      if (grant_valid) begin
         base_cnt = locked_grant ? lock_cnt : '0;
         if (!locked_grant) rr_nxt = next_idx(grant_idx);
         if (bus.core_lock[grant_idx] && base_cnt != CNT_LAST) begin
            lock_active_nxt = 1'b1;
            lock_owner_nxt  = grant_idx;
            lock_cnt_nxt    = base_cnt + 1'b1;
         end else begin
            // Lock not requested, or the forced release on its last cycle.
            lock_active_nxt = 1'b0;
            lock_cnt_nxt    = '0;
            if (locked_grant) rr_nxt = next_idx(lock_owner);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= '0;
         lock_active <= 1'b0;
         lock_owner  <= '0;
         lock_cnt    <= '0;
         grant_cnt   <= '0;
         stall_cnt   <= '0;
      end else begin
         rr_ptr      <= rr_nxt;
         lock_active <= lock_active_nxt;
         lock_owner  <= lock_owner_nxt;
         lock_cnt    <= lock_cnt_nxt;
         for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_vec[i] && grant_cnt[i] != 32'hFFFF_FFFF)
               grant_cnt[i] <= grant_cnt[i] + 32'd1;
            if (bus.core_stall[i] && stall_cnt[i] != 32'hFFFF_FFFF)
               stall_cnt[i] <= stall_cnt[i] + 32'd1;
         end
      end
   end

   always_comb begin
      stat_grants = '0;
      stat_stalls = '0;
      if (int'(stat_sel) < NUM_CORES) begin
         stat_grants = grant_cnt[stat_sel];
         stat_stalls = stall_cnt[stat_sel];
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised data-memory arbiter that lets `NUM_CORES` RISC-V cores share a single-port data memory in the multi-core system top level. Each cycle it grants at most one core's load/store using round-robin priority, with an optional bounded lock for read-modify-write sequences, and stalls every other requesting core. It drives the shared `dmem` port (combinational read, write on clock edge). It also keeps per-core grant and stall counters for performance debug.

## Interface
Parameters:
- `NUM_CORES`, 2: number of core ports, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `LOCK_MAX`, 4: maximum consecutive cycles one core may hold a lock, ≥1.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  NUM_CORES  per-core memory access request (M stage).
- `core_write`  in  NUM_CORES  per-core write enable; ignored when the request bit is 0.
- `core_lock`  in  NUM_CORES  per-core request to keep the grant on the next cycle.
- `core_addr`  in  NUM_CORES*ADDR_WIDTH  core i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `core_write_data`  in  NUM_CORES*DATA_WIDTH  core i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `core_read_data`  out  DATA_WIDTH  `mem_read_data` broadcast; meaningful only to the granted core.
- `core_grant`  out  NUM_CORES  one-hot or zero; the access of core i is performed this cycle.
- `core_stall`  out  NUM_CORES  `core_req[i] & ~core_grant[i]`.
- `mem_write`  out  1  write enable to `dmem`.
- `mem_addr`  out  ADDR_WIDTH  address to `dmem`.
- `mem_write_data`  out  DATA_WIDTH  write data to `dmem`.
- `mem_read_data`  in  DATA_WIDTH  combinational read data from `dmem`.
- `stat_sel`  in  $clog2(NUM_CORES)  selects which core's counters appear on the stat outputs.
- `stat_grants`  out  32  grant count of the selected core.
- `stat_stalls`  out  32  stall-cycle count of the selected core.

## Operation
- **State.** `rr_ptr` (reset 0), `lock_active` (reset 0), `lock_owner` (reset 0), `lock_cnt` (reset 0), and two 32-bit counters per core (reset 0).
- **Grant selection.**
  - If `lock_active` and `core_req[lock_owner]`, grant `lock_owner`.
  - Otherwise grant the first core with `req=1`, scanning `rr_ptr, rr_ptr+1, …` modulo NUM_CORES.
  - If no core requests, there is no grant.
- **Pointer update.** On a non-locked grant to core g, `rr_ptr <= (g+1) mod NUM_CORES`. With no grant, `rr_ptr` holds.
- **Lock start and hold.** A grant to g with `core_lock[g]=1` sets `lock_active<=1` and `lock_owner<=g`. On each locked cycle `lock_cnt` increments.
- **Lock release.** The lock releases, and `lock_cnt` clears, when any of these holds:
  - the owner deasserts `req` or `lock`;
  - the owner is granted with `lock_cnt == LOCK_MAX-1` (forced release; that access still completes).
- **Pointer on release.** On release, `rr_ptr <= (lock_owner+1) mod NUM_CORES`.
- **Memory side.**
  - With a grant to g: `mem_addr`, `mem_write_data` and `mem_write = core_write[g]` come from core g.
  - With no grant: `mem_addr=0`, `mem_write_data=0`, `mem_write=0`.
- **Counters.** For each core i, per cycle:
  - `grants[i]` increments on `core_grant[i]`.
  - `stalls[i]` increments on `core_stall[i]`.
  - Both saturate at 0xFFFFFFFF and never wrap.
- **Reset.** While `reset=1`, `core_grant=0`, `core_stall=0`, `mem_write=0` and `mem_addr=0` combinationally. All state clears at the edge, including any held lock (reset mid-lock drops it).

## Timing
- Grant, stall and memory-side outputs are combinational from the request inputs and current state, with zero-cycle latency.
- A granted read returns data on `core_read_data` in the same cycle.
- A granted write commits at the rising edge ending the grant cycle.
- Pointer, lock and counter updates take effect at the rising edge after the cycle in which they are evaluated.
- A stalled core holds `req`, `write`, `addr` and `write_data` stable until granted. The arbiter does not buffer requests.
- Worst-case wait for a continuously requesting core:
  - no locks: NUM_CORES-1 cycles;
  - with locks: (NUM_CORES-1)*LOCK_MAX cycles.
- `stat_grants` and `stat_stalls` are combinational from `stat_sel` and reflect counts through the previous edge.

## Test plan
- **Basic grant.** NUM_CORES=2, after reset only core1 requests a read at 0x40 -> `core_grant=2'b10`, `core_stall=0`, `mem_addr=0x40`, `rr_ptr` becomes 0.
- **Round-robin.** All 4 cores request continuously for 8 cycles from `rr_ptr=0` -> grant order 0,1,2,3,0,1,2,3. Each core shows `stat_grants=2` and `stat_stalls=6`.
- **Contended write.** Core0 writes 0xDEADBEEF to 0x10 while core1 reads 0x10 in the same cycle -> core0 granted, core1 stalled. Next cycle core1 is granted and reads 0xDEADBEEF.
- **Forced lock release.** LOCK_MAX=4, core0 holds req+lock for 6 cycles while core1 requests -> core0 granted in cycles 0-3, core1 granted in cycle 4.
- **Reset mid-lock.** Reset asserted mid-lock -> the following cycle has `lock_active=0`, `rr_ptr=0` and all counters 0. While reset is high, `mem_write=0` even with `core_write=1`.
- **Counter saturation.** Force a stall counter to 0xFFFFFFFE, then stall the core for 3 cycles -> `stat_stalls` reads 0xFFFFFFFF.
